// File: rtl/simd_thread_sequencer.sv
// simd_thread_sequencer: issues one decoded SIMD instruction to each active thread of a lane, lowest tIdx first.
// Latency: first issue registered one cycle after accept; k hazard-free threads issue on k consecutive cycles.
// Backpressure: stall freezes state/history/payload; RAW hazards insert bubbles. Optional perf counters: SIMD_SEQ_PERF_CNT_EN.
module simd_thread_sequencer #(
  parameter int NUM_THREADS = 16,
  parameter int HAZ_DEPTH   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic [4:0]                     instr_AD1,
  input  logic [4:0]                     instr_AD2,
  input  logic [4:0]                     instr_AD3,
  input  logic [4:0]                     instr_FUNCT4,
  input  logic [31:0]                    instr_IMM,
  input  logic                           instr_is_int,
  input  logic                           instr_is_float,
  input  logic                           instr_WE3,
  input  logic [NUM_THREADS-1:0]         active_mask,
  input  logic                           stall,
  output logic                           issue_valid,
  output logic [$clog2(NUM_THREADS)-1:0] tIdx,
  output logic [4:0]                     AD1,
  output logic [4:0]                     AD2,
  output logic [4:0]                     AD3,
  output logic [4:0]                     FUNCT4,
  output logic [31:0]                    IMM,
  output logic                           is_int,
  output logic                           is_float,
  output logic                           WE3,
  output logic                           busy
`ifdef SIMD_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_issued,
  output logic [31:0]                    perf_hazard,
  output logic [31:0]                    perf_stall
`endif
);

  localparam int TW = $clog2(NUM_THREADS);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0]  ad1;
    logic [4:0]  ad2;
    logic [4:0]  ad3;
    logic [4:0]  funct4;
    logic [31:0] imm;
    logic        is_int;
    logic        is_float;
    logic        we3;
  } instr_t;

  // One slot per issued cycle still in flight after ID; vld = 0 marks a bubble.
  typedef struct packed {
    logic          vld;
    logic [TW-1:0] tidx;
    logic [4:0]    ad3;
    logic          we3;
  } hist_t;

  state_t                 state_q, state_d;
  instr_t                 lat;
  logic [NUM_THREADS-1:0] rem_mask;
  hist_t                  hist [HAZ_DEPTH];

  logic [TW-1:0]          cand;
  logic [NUM_THREADS-1:0] cand_oh;
  logic                   last;
  logic                   hazard;
  logic                   fire;
  logic                   bubble;
  logic                   accept;
  logic                   hist_any;

  // Candidate thread is the lowest remaining bit; also flags whether it is the final one.
  always_comb begin
    cand    = '0;
    cand_oh = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (rem_mask[i]) cand = TW'(i);
    end
    cand_oh[cand] = 1'b1;
    last = ((rem_mask & ~cand_oh) == '0);
  end

  // RAW check: an in-flight write by the same thread to a register this instruction reads.
  always_comb begin
    hazard   = 1'b0;
    hist_any = 1'b0;
    for (int j = 0; j < HAZ_DEPTH; j++) begin
      if (hist[j].vld) hist_any = 1'b1;
      if (hist[j].vld && hist[j].we3 && (hist[j].tidx == cand) && (hist[j].ad3 != 5'd0) &&
          ((hist[j].ad3 == lat.ad1) || (hist[j].ad3 == lat.ad2))) begin
        hazard = 1'b1;
      end
    end
  end

  // Next state and handshake. instr_ready rises in the cycle the final thread is selected,
  // so a new instruction can be accepted while the final issue is being registered.
  // Stall blocks accepts too, because the state must hold under stall.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    fire        = 1'b0;
    bubble      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = !stall;
      end
      S_ISSUE: begin
        if (!stall) begin
          if (hazard) begin
            bubble = 1'b1;
          end else begin
            fire = 1'b1;
            if (last) begin
              instr_ready = 1'b1;
              state_d     = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) instr_ready = 1'b0;
    accept = instr_valid && instr_ready;
    if (accept) state_d = (active_mask != '0) ? S_ISSUE : S_IDLE;
  end

  // State, latched instruction, remaining mask and hazard history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lat      <= '0;
      rem_mask <= '0;
      for (int j = 0; j < HAZ_DEPTH; j++) hist[j] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lat <= '{ad1: instr_AD1, ad2: instr_AD2, ad3: instr_AD3, funct4: instr_FUNCT4,
                  imm: instr_IMM, is_int: instr_is_int, is_float: instr_is_float, we3: instr_WE3};
      end
      if (accept) begin
        rem_mask <= active_mask;
      end else if (fire) begin
        rem_mask <= rem_mask & ~cand_oh;
      end
      if (!stall) begin
        hist[0] <= fire ? '{vld: 1'b1, tidx: cand, ad3: lat.ad3, we3: lat.we3} : '0;
        for (int j = 1; j < HAZ_DEPTH; j++) hist[j] <= hist[j-1];
      end
    end
  end

  // Registered lane outputs; payload holds between issues, WE3 is only high with an issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      tIdx        <= '0;
      AD1         <= '0;
      AD2         <= '0;
      AD3         <= '0;
      FUNCT4      <= '0;
      IMM         <= '0;
      is_int      <= 1'b0;
      is_float    <= 1'b0;
      WE3         <= 1'b0;
    end else begin
      issue_valid <= fire;
      WE3         <= fire && lat.we3;
      if (fire) begin
        tIdx     <= cand;
        AD1      <= lat.ad1;
        AD2      <= lat.ad2;
        AD3      <= lat.ad3;
        FUNCT4   <= lat.funct4;
        IMM      <= lat.imm;
        is_int   <= lat.is_int;
        is_float <= lat.is_float;
      end
    end
  end

  assign busy = (state_q == S_ISSUE) || hist_any;

`ifdef SIMD_SEQ_PERF_CNT_EN
  // Saturating event counters: issues, hazard bubbles, stalled ISSUE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_hazard <= '0;
      perf_stall  <= '0;
    end else begin
      if (fire && (perf_issued != 32'hFFFF_FFFF)) perf_issued <= perf_issued + 32'd1;
      if (bubble && (perf_hazard != 32'hFFFF_FFFF)) perf_hazard <= perf_hazard + 32'd1;
      if (stall && (state_q == S_ISSUE) && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simd_thread_sequencer.sv
`timescale 1ns/1ps
module tb_simd_thread_sequencer;
  localparam int NT = 16;
  localparam int HD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, instr_valid, instr_ready, stall;
  logic [4:0]    instr_AD1, instr_AD2, instr_AD3, instr_FUNCT4;
  logic [31:0]   instr_IMM;
  logic          instr_is_int, instr_is_float, instr_WE3;
  logic [NT-1:0] active_mask;
  logic          issue_valid, is_int, is_float, WE3, busy;
  logic [3:0]    tIdx;
  logic [4:0]    AD1, AD2, AD3, FUNCT4;
  logic [31:0]   IMM;
`ifdef SIMD_SEQ_PERF_CNT_EN
  logic [31:0]   perf_issued, perf_hazard, perf_stall;
`endif

  simd_thread_sequencer #(.NUM_THREADS(NT), .HAZ_DEPTH(HD)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_AD1(instr_AD1), .instr_AD2(instr_AD2), .instr_AD3(instr_AD3),
    .instr_FUNCT4(instr_FUNCT4), .instr_IMM(instr_IMM), .instr_is_int(instr_is_int),
    .instr_is_float(instr_is_float), .instr_WE3(instr_WE3), .active_mask(active_mask),
    .stall(stall), .issue_valid(issue_valid), .tIdx(tIdx), .AD1(AD1), .AD2(AD2), .AD3(AD3),
    .FUNCT4(FUNCT4), .IMM(IMM), .is_int(is_int), .is_float(is_float), .WE3(WE3), .busy(busy)
`ifdef SIMD_SEQ_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_hazard(perf_hazard), .perf_stall(perf_stall)
`endif
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model ----------------
  // An instruction is in progress exactly while threads remain; the history is a list of
  // recent issue slots, newest first, at most HD long.
  typedef struct { bit vld; int t; int ad3; bit we3; } hent_t;
  hent_t       m_hist[$];
  bit [NT-1:0] m_rem;
  int          m_ad1, m_ad2, m_ad3, m_f4;
  bit [31:0]   m_imm;
  bit          m_int, m_flt, m_we3;
  bit          m_iv, m_o_int, m_o_flt, m_o_we3;
  int          m_t, m_o_ad1, m_o_ad2, m_o_ad3, m_o_f4;
  bit [31:0]   m_o_imm;
  int          m_pi, m_ph, m_ps;

  task automatic m_reset();
    m_hist.delete();
    m_rem = '0; m_ad1 = 0; m_ad2 = 0; m_ad3 = 0; m_f4 = 0; m_imm = '0;
    m_int = 0; m_flt = 0; m_we3 = 0;
    m_iv = 0; m_o_int = 0; m_o_flt = 0; m_o_we3 = 0;
    m_t = 0; m_o_ad1 = 0; m_o_ad2 = 0; m_o_ad3 = 0; m_o_f4 = 0; m_o_imm = '0;
    m_pi = 0; m_ph = 0; m_ps = 0;
  endtask

  function automatic int lowest(bit [NT-1:0] m);
    for (int i = 0; i < NT; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic bit m_hazard(int t);
    foreach (m_hist[k])
      if (m_hist[k].vld && m_hist[k].we3 && m_hist[k].t == t && m_hist[k].ad3 != 0 &&
          (m_hist[k].ad3 == m_ad1 || m_hist[k].ad3 == m_ad2)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    if (rst || stall) return 1'b0;
    if (m_rem == '0) return 1'b1;
    return !m_hazard(lowest(m_rem)) && ($countones(m_rem) == 1);
  endfunction

  function automatic bit m_busy();
    if (m_rem != '0) return 1'b1;
    foreach (m_hist[k]) if (m_hist[k].vld) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model across the next clock edge using the inputs now applied.
  task automatic m_step();
    int t; bit haz, fire, rdy; hent_t e;
    if (rst) begin m_reset(); return; end
    if (stall) begin
      m_iv = 0; m_o_we3 = 0;
      if (m_rem != '0) m_ps++;
      return;
    end
    rdy  = m_ready();
    t    = lowest(m_rem);
    haz  = (t >= 0) && m_hazard(t);
    fire = (t >= 0) && !haz;
    e.vld = fire; e.t = t; e.ad3 = m_ad3; e.we3 = m_we3;
    m_hist.push_front(e);
    if (m_hist.size() > HD) void'(m_hist.pop_back());
    m_iv = fire;
    m_o_we3 = fire && m_we3;
    if (fire) begin
      m_t = t; m_o_ad1 = m_ad1; m_o_ad2 = m_ad2; m_o_ad3 = m_ad3; m_o_f4 = m_f4;
      m_o_imm = m_imm; m_o_int = m_int; m_o_flt = m_flt;
      m_rem[t] = 1'b0;
      m_pi++;
    end
    if (haz) m_ph++;
    if (instr_valid && rdy) begin
      m_ad1 = int'(instr_AD1); m_ad2 = int'(instr_AD2); m_ad3 = int'(instr_AD3);
      m_f4 = int'(instr_FUNCT4); m_imm = instr_IMM; m_int = instr_is_int;
      m_flt = instr_is_float; m_we3 = instr_WE3; m_rem = active_mask;
    end
  endtask

  // ---------------- logs for hand-computed expectations ----------------
  int iss_cyc[$];
  int iss_t[$];
  bit rdy_seen [0:16383];

  // Compare process: every cycle, 4 ns after the edge, check outputs and then step the model.
  initial m_reset();
  always begin
    @(posedge clk);
    #4;
    cyc++;
    chk("issue_valid", 64'(issue_valid), 64'(m_iv));
    chk("WE3", 64'(WE3), 64'(m_o_we3));
    chk("busy", 64'(busy), 64'(m_busy()));
    chk("tIdx", 64'(tIdx), 64'(m_t));
    chk("AD1", 64'(AD1), 64'(m_o_ad1));
    chk("AD2", 64'(AD2), 64'(m_o_ad2));
    chk("AD3", 64'(AD3), 64'(m_o_ad3));
    chk("FUNCT4", 64'(FUNCT4), 64'(m_o_f4));
    chk("IMM", 64'(IMM), 64'(m_o_imm));
    chk("is_int", 64'(is_int), 64'(m_o_int));
    chk("is_float", 64'(is_float), 64'(m_o_flt));
    chk("instr_ready", 64'(instr_ready), 64'(m_ready()));
`ifdef SIMD_SEQ_PERF_CNT_EN
    chk("perf_issued", 64'(perf_issued), 64'(m_pi));
    chk("perf_hazard", 64'(perf_hazard), 64'(m_ph));
    chk("perf_stall", 64'(perf_stall), 64'(m_ps));
`endif
    if (issue_valid) begin iss_cyc.push_back(cyc); iss_t.push_back(int'(tIdx)); end
    if (cyc < 16384) rdy_seen[cyc] = instr_ready;
    m_step();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [NT-1:0] mask, input int a1, input int a2, input int a3,
                      input bit we, input int f4, input logic [31:0] imm, input bit ii, input bit fl);
    instr_valid = 1'b1; active_mask = mask;
    instr_AD1 = 5'(a1); instr_AD2 = 5'(a2); instr_AD3 = 5'(a3); instr_WE3 = we;
    instr_FUNCT4 = 5'(f4); instr_IMM = imm; instr_is_int = ii; instr_is_float = fl;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (instr_ready) begin step(); instr_valid = 1'b0; return; end
      step();
    end
    instr_valid = 1'b0;
    note_fail("send_accept");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      if (!busy) return;
      step();
    end
    note_fail("wait_idle");
  endtask

  initial begin
    int base, n, first;
    bit seen, accepted;
    rst = 1'b1; stall = 1'b0; instr_valid = 1'b0; active_mask = '0;
    instr_AD1 = '0; instr_AD2 = '0; instr_AD3 = '0; instr_FUNCT4 = '0; instr_IMM = '0;
    instr_is_int = 1'b0; instr_is_float = 1'b0; instr_WE3 = 1'b0;
    step(); step();
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready_low", 64'(instr_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready_high", 64'(instr_ready), 64'd1);

    // Full mask: 16 consecutive issues, ready during selection of thread 15.
    base = iss_cyc.size();
    send(16'hFFFF, 1, 2, 3, 1, 4, 32'hCAFE_0001, 1, 0);
    wait_idle(); step();
    chk("s1_count", 64'(iss_cyc.size() - base), 64'd16);
    if (iss_cyc.size() - base == 16) begin
      first = iss_cyc[base];
      for (int k = 0; k < 16; k++) begin
        chk("s1_tidx_order", 64'(iss_t[base+k]), 64'(k));
        chk("s1_consecutive", 64'(iss_cyc[base+k]), 64'(first + k));
      end
      chk("s1_ready_with_t15", 64'(rdy_seen[iss_cyc[base+15]-1]), 64'd1);
      chk("s1_ready_not_t14", 64'(rdy_seen[iss_cyc[base+14]-1]), 64'd0);
    end

    // RAW on x5 by thread 0: three bubbles.
    base = iss_cyc.size();
    send(16'h0001, 1, 2, 5, 1, 1, 32'h11, 1, 0);
    send(16'h0001, 5, 0, 6, 1, 2, 32'h22, 1, 0);
    wait_idle(); step();
    chk("s2_count", 64'(iss_cyc.size() - base), 64'd2);
    if (iss_cyc.size() - base == 2) chk("s2_gap", 64'(iss_cyc[base+1] - iss_cyc[base]), 64'd4);

    // Register 0 never hazards: back-to-back issues.
    base = iss_cyc.size();
    send(16'h0001, 1, 2, 0, 1, 3, 32'h33, 0, 1);
    send(16'h0001, 0, 3, 4, 1, 4, 32'h44, 0, 1);
    wait_idle(); step();
    chk("s3_count", 64'(iss_cyc.size() - base), 64'd2);
    if (iss_cyc.size() - base == 2) chk("s3_gap", 64'(iss_cyc[base+1] - iss_cyc[base]), 64'd1);

    // Stall for 4 cycles after the first issue of mask 00A0.
    base = iss_cyc.size();
    send(16'h00A0, 1, 2, 3, 1, 5, 32'h55, 1, 0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (issue_valid) begin seen = 1'b1; break; end
      step();
    end
    if (!seen) note_fail("s4_first_issue");
    stall = 1'b1;
    repeat (4) step();
    stall = 1'b0;
    wait_idle(); step();
    chk("s4_count", 64'(iss_cyc.size() - base), 64'd2);
    if (iss_cyc.size() - base == 2) begin
      chk("s4_t0", 64'(iss_t[base]), 64'd5);
      chk("s4_t1", 64'(iss_t[base+1]), 64'd7);
      chk("s4_gap", 64'(iss_cyc[base+1] - iss_cyc[base]), 64'd5);
    end

    // Empty mask: consumed, nothing issues, never busy.
    base = iss_cyc.size();
    send(16'h0000, 1, 2, 3, 1, 6, 32'h66, 1, 0);
    for (int k = 0; k < 6; k++) begin
      chk("s5_ready", 64'(instr_ready), 64'd1);
      chk("s5_busy", 64'(busy), 64'd0);
      step();
    end
    chk("s5_no_issue", 64'(iss_cyc.size() - base), 64'd0);

    // Reset with 8 threads remaining.
    base = iss_cyc.size();
    n = 0;
    send(16'hFFFF, 7, 8, 9, 1, 7, 32'h77, 1, 0);
    for (int k = 0; k < 60 && n < 8; k++) begin
      if (issue_valid) n++;
      if (n < 8) step();
    end
    if (n < 8) note_fail("s6_eight_issues");
    rst = 1'b1;
    step();
    chk("s6_issue_valid", 64'(issue_valid), 64'd0);
    chk("s6_busy", 64'(busy), 64'd0);
`ifdef SIMD_SEQ_PERF_CNT_EN
    chk("s6_perf_issued", 64'(perf_issued), 64'd0);
    chk("s6_perf_hazard", 64'(perf_hazard), 64'd0);
    chk("s6_perf_stall", 64'(perf_stall), 64'd0);
`endif
    rst = 1'b0;
    #1;
    chk("s6_idle_ready", 64'(instr_ready), 64'd1);
    repeat (10) step();
    chk("s6_total_issues", 64'(iss_cyc.size() - base), 64'd8);

    // Randomised traffic with stalls, hazards and occasional reset.
    accepted = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (!instr_valid || accepted) begin
        instr_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: active_mask = '0;
          1: active_mask = NT'(1) << $urandom_range(0, NT - 1);
          2: active_mask = NT'($urandom);
          default: active_mask = 16'hFFFF;
        endcase
        instr_AD1 = 5'($urandom_range(0, 3)); instr_AD2 = 5'($urandom_range(0, 3));
        instr_AD3 = 5'($urandom_range(0, 3)); instr_WE3 = 1'($urandom_range(0, 1));
        instr_FUNCT4 = 5'($urandom); instr_IMM = $urandom;
        instr_is_int = 1'($urandom_range(0, 1)); instr_is_float = 1'($urandom_range(0, 1));
      end
      stall = ($urandom_range(0, 6) == 0);
      rst = ($urandom_range(0, 299) == 0);
      #1;
      accepted = instr_valid && instr_ready;
      step();
    end
    rst = 1'b0; stall = 1'b0; instr_valid = 1'b0;
    wait_idle(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
